// File: rtl/decode_pkg.sv
// Shared decode definitions: instruction layout, opcodes, FSM states and branch target helper.
package decode_pkg;

   localparam int REG_W   = 4;
   localparam int INSTR_W = 32;
   localparam int IMM_W   = 16;

   typedef enum logic [3:0] {
      OP_NOP = 4'h0,
      OP_ALU = 4'h1,
      OP_LD  = 4'h2,
      OP_ST  = 4'h3,
      OP_B   = 4'h8,
      OP_BEQ = 4'h9,
      OP_BNE = 4'hA
   } opcode_e;

   typedef struct packed {
      opcode_e            opc;
      logic [REG_W-1:0]   rd;
      logic [REG_W-1:0]   rs1;
      logic [REG_W-1:0]   rs2;
      logic [IMM_W-1:0]   imm;
   } instr_t;

   localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

   typedef enum logic [0:0] {
      ST_RUN    = 1'b0,
      ST_SQUASH = 1'b1
   } state_e;

   // Word-offset immediate, sign-extended; wraps silently at 32 bits.
   function automatic logic [INSTR_W-1:0] branch_target(input logic [INSTR_W-1:0] pc,
                                                         input logic [IMM_W-1:0]   imm);
      return pc + {{(INSTR_W-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/decode_branch_ctrl_hazard.sv
// Load-use detector: flags an ID instruction reading the register a load in EX is still producing.
module hazard_detect_unit
   import decode_pkg::*;
(
   input  logic             id_valid_i,
   input  logic             ex_is_load_i,
   input  logic [REG_W-1:0] ex_rd_i,
   input  logic [REG_W-1:0] rs1_addr_i,
   input  logic [REG_W-1:0] rs2_addr_i,
   output logic             hazard_o
);

   assign hazard_o = id_valid_i && ex_is_load_i &&
                     ((ex_rd_i == rs1_addr_i) || (ex_rd_i == rs2_addr_i));

endmodule

// File: rtl/decode_branch_ctrl.sv
// IF/ID register with branch resolution, fetch stall control and wrong-path squashing.
// en/branchFlag/branchAddr are combinational; everything toward EX is registered (1 cycle).
module decode_branch_ctrl
   import decode_pkg::*;
#(
   parameter int SQUASH_CYCLES = 0
)(
   input  logic               clk,
   input  logic               rst,
   input  logic [INSTR_W-1:0] instruction,
   input  logic [INSTR_W-1:0] pc,
   input  logic               ex_stall,
   input  logic               ex_is_load,
   input  logic [REG_W-1:0]   ex_rd,
   input  logic [INSTR_W-1:0] rs1_data,
   input  logic [INSTR_W-1:0] rs2_data,
   output logic [REG_W-1:0]   rs1_addr,
   output logic [REG_W-1:0]   rs2_addr,
   output logic               en,
   output logic               branchFlag,
   output logic [INSTR_W-1:0] branchAddr,
   output logic               id_valid,
   output logic [INSTR_W-1:0] id_instruction,
   output logic [INSTR_W-1:0] id_pc
);

   localparam int              CNT_W   = (SQUASH_CYCLES < 2) ? 1 : $clog2(SQUASH_CYCLES + 1);
   localparam logic [CNT_W-1:0] SQ_LOAD = CNT_W'(SQUASH_CYCLES);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   instr_t             id_instr_q, id_instr_d;
   logic [INSTR_W-1:0] id_pc_q, id_pc_d;
   logic               id_valid_q, id_valid_d;

   logic               hazard;
   logic               cond_met;
   logic               taken;
   logic               advance;

   hazard_detect_unit u_hazard (
      .id_valid_i   (id_valid_q),
      .ex_is_load_i (ex_is_load),
      .ex_rd_i      (ex_rd),
      .rs1_addr_i   (id_instr_q.rs1),
      .rs2_addr_i   (id_instr_q.rs2),
      .hazard_o     (hazard)
   );

   always_comb begin
      cond_met = 1'b0;
      case (id_instr_q.opc)
         OP_B:    cond_met = 1'b1;
         OP_BEQ:  cond_met = (rs1_data == rs2_data);
         OP_BNE:  cond_met = (rs1_data != rs2_data);
         default: cond_met = 1'b0;
      endcase
   end

   // No branch may resolve while wrong-path slots are still draining.
   assign taken   = id_valid_q && (state_q == ST_RUN) && cond_met;
   assign advance = rst && !ex_stall && !hazard;

   assign en         = advance;
   assign branchFlag = advance && taken;
   assign branchAddr = branchFlag ? branch_target(id_pc_q, id_instr_q.imm) : '0;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      id_instr_d = id_instr_q;
      id_pc_d    = id_pc_q;
      id_valid_d = id_valid_q;
      if (!ex_stall && !hazard) begin
         if (taken) begin
            // The instruction fetched alongside the redirect is on the wrong path.
            id_instr_d = instr_t'(NOP);
            id_pc_d    = pc;
            id_valid_d = 1'b0;
            if (SQUASH_CYCLES > 0) begin
               state_d = ST_SQUASH;
               cnt_d   = SQ_LOAD;
            end
         end else if (state_q == ST_SQUASH) begin
            id_instr_d = instr_t'(instruction);
            id_pc_d    = pc;
            id_valid_d = 1'b0;
            cnt_d      = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_RUN;
            end
         end else begin
            id_instr_d = instr_t'(instruction);
            id_pc_d    = pc;
            id_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_RUN;
         cnt_q      <= '0;
         id_instr_q <= instr_t'(NOP);
         id_pc_q    <= '0;
         id_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         id_instr_q <= id_instr_d;
         id_pc_q    <= id_pc_d;
         id_valid_q <= id_valid_d;
      end
   end

   assign rs1_addr       = id_instr_q.rs1;
   assign rs2_addr       = id_instr_q.rs2;
   assign id_valid       = id_valid_q;
   assign id_instruction = id_instr_q;
   assign id_pc          = id_pc_q;

endmodule
